// File: rtl/ysyx_22050039_exec_ctrl_if.sv
// ============================================================================
// Module   : ysyx_22050039_exec_ctrl_if
// Purpose  : Handshake/strobe bundle between the exec sequencer and IFU/IDU/LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ysyx_22050039_exec_ctrl_if #(
  parameter int XLEN = 64
);
  logic            ifu_req;
  logic            ifu_ack;
  logic            dec_ebreak;
  logic            dec_invalid;
  logic            dec_load;
  logic            dec_store;
  logic            dec_rd_wen;
  logic [4:0]      dec_rd;
  logic            mem_req;
  logic            mem_wen;
  logic            mem_ack;
  logic            reg_wen;
  logic            pc_wen;
  logic            halt;
  logic [1:0]      halt_code;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret_cnt;

  // master: the sequencer; slave: the memories, decoder and register heap
  modport master (
    output ifu_req, mem_req, mem_wen, reg_wen, pc_wen, halt, halt_code,
           cycle_cnt, instret_cnt,
    input  ifu_ack, dec_ebreak, dec_invalid, dec_load, dec_store,
           dec_rd_wen, dec_rd, mem_ack
  );

  modport slave (
    input  ifu_req, mem_req, mem_wen, reg_wen, pc_wen, halt, halt_code,
           cycle_cnt, instret_cnt,
    output ifu_ack, dec_ebreak, dec_invalid, dec_load, dec_store,
           dec_rd_wen, dec_rd, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050039_exec_ctrl.sv
// ============================================================================
// Module   : ysyx_22050039_exec_ctrl
// Purpose  : Multi-cycle IF/ID/EX/MEM/WB sequencer with halt, timeout, counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22050039_exec_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22050039_exec_ctrl_if.master ctrl_io
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(TIMEOUT);
  localparam logic [1:0]      CODE_EBREAK  = 2'd0;
  localparam logic [1:0]      CODE_INVALID = 2'd1;
  localparam logic [1:0]      CODE_TIMEOUT = 2'd2;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            is_load_q, is_load_d;
  logic            is_store_q, is_store_d;
  logic            rd_wen_q, rd_wen_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      halt_code_q, halt_code_d;

  logic            ifu_req_q;
  logic            mem_req_q;
  logic            mem_wen_q;
  logic            reg_wen_q;
  logic            pc_wen_q;
  logic            halt_q;
  logic [XLEN-1:0] cycle_q;
  logic [XLEN-1:0] instret_q;

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    rd_wen_d    = rd_wen_q;
    rd_d        = rd_q;
    halt_code_d = halt_code_q;

    case (state_q)
      S_IF: begin
        if (ctrl_io.ifu_ack) begin
          state_d = S_ID;
        end else if (wait_q == TIMEOUT_LIM) begin
          state_d     = S_HALT;
          halt_code_d = CODE_TIMEOUT;
        end
      end
      S_ID: begin
        // a load+store collision is resolved as a store
        is_store_d = ctrl_io.dec_store;
        is_load_d  = ctrl_io.dec_load & ~ctrl_io.dec_store;
        rd_wen_d   = ctrl_io.dec_rd_wen;
        rd_d       = ctrl_io.dec_rd;
        if (ctrl_io.dec_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = CODE_EBREAK;
        end else if (ctrl_io.dec_invalid) begin
          state_d     = S_HALT;
          halt_code_d = CODE_INVALID;
        end else if (ctrl_io.dec_load || ctrl_io.dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX:  state_d = S_WB;
      S_MEM: begin
        if (ctrl_io.mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == TIMEOUT_LIM) begin
          state_d     = S_HALT;
          halt_code_d = CODE_TIMEOUT;
        end
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Counter restarts on every state change, so entering IF or MEM sees 0
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == S_IF || state_q == S_MEM) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IF;
      wait_q      <= '0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      rd_wen_q    <= 1'b0;
      rd_q        <= 5'd0;
      halt_code_q <= 2'd0;
      // the fetch request follows the IF state straight out of reset
      ifu_req_q   <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      reg_wen_q   <= 1'b0;
      pc_wen_q    <= 1'b0;
      halt_q      <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      rd_wen_q    <= rd_wen_d;
      rd_q        <= rd_d;
      halt_code_q <= halt_code_d;

      ifu_req_q <= (state_d == S_IF);
      mem_req_q <= (state_d == S_MEM) && (is_load_d || is_store_d);
      mem_wen_q <= (state_d == S_MEM) && is_store_d;
      pc_wen_q  <= (state_d == S_WB);
      reg_wen_q <= (state_d == S_WB) && rd_wen_d && (rd_d != 5'd0);
      halt_q    <= (state_d == S_HALT);

      if (state_q != S_HALT) begin
        cycle_q <= cycle_q + XLEN'(1);
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + XLEN'(1);
      end
    end
  end

  assign ctrl_io.ifu_req     = ifu_req_q;
  assign ctrl_io.mem_req     = mem_req_q;
  assign ctrl_io.mem_wen     = mem_wen_q;
  assign ctrl_io.reg_wen     = reg_wen_q;
  assign ctrl_io.pc_wen      = pc_wen_q;
  assign ctrl_io.halt        = halt_q;
  assign ctrl_io.halt_code   = halt_code_q;
  assign ctrl_io.cycle_cnt   = cycle_q;
  assign ctrl_io.instret_cnt = instret_q;

endmodule

`default_nettype wire
